// File: rtl/ulpi_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ulpi_rx_decoder
//  Description : ULPI receive-side decoder for the USB3300 sniffer. Registers
//                DIR/NXT/data, handles bus turnaround, decodes RX CMD bytes
//                into line/VBUS/event status and frames packet data bytes
//                (SOP/EOP/length/error) for the capture FIFO.
//                Optional feature macro: ULPI_RX_TIMESTAMP_EN (latches a
//                free-running 16-bit cycle counter on each packet's SOP).
//  Revision    : 1.0 - initial release
// ============================================================================
module ulpi_rx_decoder #(
  parameter int MAX_PKT_LEN = 1027,
  parameter int LEN_W       = 11
) (
  input  logic             clk_ext,
  input  logic             rst,
  input  logic             DIR,
  input  logic             NXT,
  input  logic [7:0]       ULPI_DATA_IN,
  input  logic             RX_FULL,
  output logic [7:0]       RX_DATA,
  output logic             RX_VALID,
  output logic             RX_SOP,
  output logic             RX_EOP,
  output logic [LEN_W-1:0] PKT_LEN,
  output logic             RX_ERR,
  output logic [1:0]       LINESTATE,
  output logic [1:0]       VBUS_STATE,
  output logic [1:0]       RX_EVENT,
  output logic             ID_GND,
  output logic             RXCMD_UPD,
  output logic             RX_ACTIVE,
  output logic [15:0]      RX_TSTAMP
);

  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_PKT_LEN);

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_IDLE = 3'd1,
    S_TURN = 3'd2,
    S_CMD  = 3'd3,
    S_PKT  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_dir;
  logic             r_nxt;
  logic [7:0]       r_data;
  logic             r_full;
  logic             r_in_vld;

  logic [LEN_W-1:0] r_len;
  logic             r_rxerr;
  logic             r_ovf;
  logic             r_trunc;

  logic             w_rxcmd;
  logic             w_data;
  logic             w_eop;
  logic             w_err_evt;
  logic             w_accept;
  logic             w_unused;

  // Alt_int (RX CMD bit 7) carries no information for the sniffer.
  assign w_unused = r_data[7];

  // Input stage: every PHY pin is sampled once. RX_FULL travels with the data
  // so the full flag applies to the byte on the bus in the same cycle.
  always_ff @(posedge clk_ext or negedge rst) begin
    if (!rst) begin
      r_dir    <= 1'b0;
      r_nxt    <= 1'b0;
      r_data   <= 8'h00;
      r_full   <= 1'b0;
      r_in_vld <= 1'b0;
    end else begin
      r_dir    <= DIR;
      r_nxt    <= NXT;
      r_data   <= ULPI_DATA_IN;
      r_full   <= RX_FULL;
      r_in_vld <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_ext or negedge rst) begin
    if (!rst) r_state <= S_SYNC;
    else      r_state <= w_state_nxt;
  end

  // Next-state and sample classification. The sample that moves IDLE->TURN
  // is the rising turnaround and is discarded; from TURN the following
  // sample is already PHY data and is handled exactly like CMD. Any sample
  // with DIR low after DIR was high is the falling turnaround.
  always_comb begin
    w_state_nxt = r_state;
    w_rxcmd     = 1'b0;
    w_data      = 1'b0;
    w_eop       = 1'b0;
    w_err_evt   = 1'b0;
    case (r_state)
      S_SYNC: begin
        // r_in_vld blocks the reset value of r_dir from looking like DIR=0.
        if (r_in_vld && !r_dir) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (r_dir) w_state_nxt = S_TURN;
      end
      S_TURN, S_CMD: begin
        if (!r_dir) begin
          w_state_nxt = S_IDLE;
        end else if (r_nxt) begin
          w_data      = 1'b1;
          w_state_nxt = S_PKT;
        end else begin
          w_rxcmd = 1'b1;
          if (r_data[5:4] == 2'b01) w_state_nxt = S_PKT;
          else                      w_state_nxt = S_CMD;
        end
      end
      S_PKT: begin
        if (!r_dir) begin
          w_eop       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_nxt) begin
          w_data = 1'b1;
        end else begin
          w_rxcmd = 1'b1;
          case (r_data[5:4])
            2'b00, 2'b10: begin
              w_eop       = 1'b1;
              w_state_nxt = S_CMD;
            end
            2'b11:   w_err_evt = 1'b1;
            default: ;
          endcase
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  // A data byte reaches the FIFO only when there is room and the length
  // limit has not been reached.
  assign w_accept = w_data && !r_full && (r_len != c_MAX_LEN);

  // Output framing, status capture, length counter and sticky error flags.
  always_ff @(posedge clk_ext or negedge rst) begin
    if (!rst) begin
      RX_DATA    <= 8'h00;
      RX_VALID   <= 1'b0;
      RX_SOP     <= 1'b0;
      RX_EOP     <= 1'b0;
      PKT_LEN    <= '0;
      RX_ERR     <= 1'b0;
      LINESTATE  <= 2'b00;
      VBUS_STATE <= 2'b00;
      RX_EVENT   <= 2'b00;
      ID_GND     <= 1'b0;
      RXCMD_UPD  <= 1'b0;
      RX_ACTIVE  <= 1'b0;
      r_len      <= '0;
      r_rxerr    <= 1'b0;
      r_ovf      <= 1'b0;
      r_trunc    <= 1'b0;
    end else begin
      RX_VALID  <= 1'b0;
      RX_SOP    <= 1'b0;
      RX_EOP    <= 1'b0;
      RX_ERR    <= 1'b0;
      RXCMD_UPD <= 1'b0;
      RX_ACTIVE <= (w_state_nxt == S_PKT);

      if (w_rxcmd) begin
        LINESTATE  <= r_data[1:0];
        VBUS_STATE <= r_data[3:2];
        RX_EVENT   <= r_data[5:4];
        ID_GND     <= r_data[6];
        RXCMD_UPD  <= 1'b1;
      end

      if (w_data) begin
        if (r_full) begin
          r_ovf <= 1'b1;
        end else if (r_len == c_MAX_LEN) begin
          r_trunc <= 1'b1;
        end
      end

      if (w_accept) begin
        RX_DATA  <= r_data;
        RX_VALID <= 1'b1;
        RX_SOP   <= (r_len == '0);
        r_len    <= r_len + LEN_W'(1);
      end

      if (w_err_evt) r_rxerr <= 1'b1;

      // EOP is only raised on RX CMD or turnaround samples, so it can never
      // share a cycle with a data byte or SOP.
      if (w_eop) begin
        RX_EOP  <= 1'b1;
        PKT_LEN <= r_len;
        RX_ERR  <= r_rxerr | r_ovf | r_trunc;
        r_len   <= '0;
        r_rxerr <= 1'b0;
        r_ovf   <= 1'b0;
        r_trunc <= 1'b0;
      end
    end
  end

`ifdef ULPI_RX_TIMESTAMP_EN
  logic [15:0] r_ts_cnt;
  logic [15:0] r_tstamp;

  // Free-running cycle counter, sampled when a packet's first byte is taken.
  always_ff @(posedge clk_ext or negedge rst) begin
    if (!rst) begin
      r_ts_cnt <= 16'h0000;
      r_tstamp <= 16'h0000;
    end else begin
      r_ts_cnt <= r_ts_cnt + 16'h0001;
      if (w_accept && (r_len == '0)) r_tstamp <= r_ts_cnt;
    end
  end

  assign RX_TSTAMP = r_tstamp;
`else
  assign RX_TSTAMP = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ulpi_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ulpi_rx_decoder
//  Description : Directed self-checking bench for ulpi_rx_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ulpi_rx_decoder;

  localparam int MAX = 1027;
  localparam int LW  = 11;

  logic          clk_ext = 1'b0;
  logic          rst = 1'b0;
  logic          DIR = 1'b0;
  logic          NXT = 1'b0;
  logic [7:0]    ULPI_DATA_IN = 8'h00;
  logic          RX_FULL = 1'b0;
  logic [7:0]    RX_DATA;
  logic          RX_VALID;
  logic          RX_SOP;
  logic          RX_EOP;
  logic [LW-1:0] PKT_LEN;
  logic          RX_ERR;
  logic [1:0]    LINESTATE;
  logic [1:0]    VBUS_STATE;
  logic [1:0]    RX_EVENT;
  logic          ID_GND;
  logic          RXCMD_UPD;
  logic          RX_ACTIVE;
  logic [15:0]   RX_TSTAMP;

  ulpi_rx_decoder #(.MAX_PKT_LEN(MAX), .LEN_W(LW)) dut (
    .clk_ext(clk_ext), .rst(rst), .DIR(DIR), .NXT(NXT),
    .ULPI_DATA_IN(ULPI_DATA_IN), .RX_FULL(RX_FULL),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_SOP(RX_SOP), .RX_EOP(RX_EOP),
    .PKT_LEN(PKT_LEN), .RX_ERR(RX_ERR), .LINESTATE(LINESTATE),
    .VBUS_STATE(VBUS_STATE), .RX_EVENT(RX_EVENT), .ID_GND(ID_GND),
    .RXCMD_UPD(RXCMD_UPD), .RX_ACTIVE(RX_ACTIVE), .RX_TSTAMP(RX_TSTAMP)
  );

  always #5 clk_ext = ~clk_ext;

  int            checks = 0;
  int            errors = 0;

  // Output monitor (sampled on the falling edge).
  int            n_valid = 0;
  int            n_sop = 0;
  int            n_eop = 0;
  int            n_upd = 0;
  int            n_clash = 0;
  logic [7:0]    byte_log [0:4095];
  logic [15:0]   ts_log [0:15];
  logic [7:0]    sop_data = 8'h00;
  logic [LW-1:0] eop_len = '0;
  logic          eop_err = 1'b0;

  always @(negedge clk_ext) begin
    if (RX_VALID) begin
      byte_log[n_valid % 4096] <= RX_DATA;
      n_valid <= n_valid + 1;
      if (RX_SOP) begin
        sop_data <= RX_DATA;
        ts_log[n_sop % 16] <= RX_TSTAMP;
        n_sop <= n_sop + 1;
      end
    end
    if (RX_EOP) begin
      n_eop   <= n_eop + 1;
      eop_len <= PKT_LEN;
      eop_err <= RX_ERR;
      if (RX_SOP) n_clash <= n_clash + 1;
    end
    if (RXCMD_UPD) n_upd <= n_upd + 1;
  end

  int b_valid, b_sop, b_eop, b_upd;

  task automatic snap();
    b_valid = n_valid;
    b_sop   = n_sop;
    b_eop   = n_eop;
    b_upd   = n_upd;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic d, input logic n, input logic [7:0] x, input logic f);
    @(negedge clk_ext);
    DIR = d;
    NXT = n;
    ULPI_DATA_IN = x;
    RX_FULL = f;
  endtask

  task automatic idle(input int k);
    repeat (k) drv(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Turnaround, RX CMD RxActive, C3/01/02, RX CMD end, DIR falls.
  task automatic send_std(input logic full2);
    drv(1'b1, 1'b0, 8'hFF, 1'b0);
    drv(1'b1, 1'b0, 8'h10, 1'b0);
    drv(1'b1, 1'b1, 8'hC3, 1'b0);
    drv(1'b1, 1'b1, 8'h01, full2);
    check("active_in_pkt", 32'(RX_ACTIVE), 32'd1);
    drv(1'b1, 1'b1, 8'h02, 1'b0);
    check("lat2_valid_sop_data", {22'd0, RX_VALID, RX_SOP, RX_DATA}, {22'd0, 1'b1, 1'b1, 8'hC3});
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    idle(4);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("reset_outs", {RX_DATA, RX_VALID, RX_SOP, RX_EOP, PKT_LEN, RX_ERR, LINESTATE,
                         VBUS_STATE, RX_EVENT, ID_GND, RXCMD_UPD, RX_ACTIVE}, 32'd0);
    check("reset_tstamp", 32'(RX_TSTAMP), 32'd0);
    @(negedge clk_ext);
    rst = 1'b1;
    idle(4);

    // RX CMD 11 alone, then DIR falls: empty packet
    snap();
    drv(1'b1, 1'b0, 8'hFF, 1'b0);
    drv(1'b1, 1'b0, 8'h11, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    idle(4);
    check("t1_upd", 32'(n_upd - b_upd), 32'd1);
    check("t1_status", {28'd0, LINESTATE, RX_EVENT}, {28'd0, 2'b01, 2'b01});
    check("t1_no_valid", 32'(n_valid - b_valid), 32'd0);
    check("t1_eop_cnt", 32'(n_eop - b_eop), 32'd1);
    check("t1_eop_len0", 32'(eop_len), 32'd0);
    check("t1_no_sop", 32'(n_sop - b_sop), 32'd0);
    check("t1_inactive", 32'(RX_ACTIVE), 32'd0);

    // Normal three-byte packet
    snap();
    send_std(1'b0);
    check("t2_valid", 32'(n_valid - b_valid), 32'd3);
    check("t2_bytes", {8'd0, byte_log[b_valid % 4096], byte_log[(b_valid + 1) % 4096],
                       byte_log[(b_valid + 2) % 4096]}, 32'h00C30102);
    check("t2_sop", 32'(n_sop - b_sop), 32'd1);
    check("t2_eop", 32'(n_eop - b_eop), 32'd1);
    check("t2_len_err", {20'd0, eop_len, eop_err}, {20'd0, 11'd3, 1'b0});
    check("t2_upd", 32'(n_upd - b_upd), 32'd2);
`ifndef ULPI_RX_TIMESTAMP_EN
    check("t2_tstamp_tied", 32'(RX_TSTAMP), 32'd0);
`endif

    // FIFO full on the second byte
    snap();
    send_std(1'b1);
    check("t3_valid", 32'(n_valid - b_valid), 32'd2);
    check("t3_second", 32'(byte_log[(b_valid + 1) % 4096]), 32'h02);
    check("t3_len_err", {20'd0, eop_len, eop_err}, {20'd0, 11'd2, 1'b1});

    // 1030 bytes: truncated at MAX
    snap();
    drv(1'b1, 1'b0, 8'hFF, 1'b0);
    drv(1'b1, 1'b0, 8'h10, 1'b0);
    for (int i = 0; i < 1030; i++) drv(1'b1, 1'b1, i[7:0], 1'b0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    idle(4);
    check("t4_valid", 32'(n_valid - b_valid), 32'd1027);
    check("t4_len_err", {20'd0, eop_len, eop_err}, {20'd0, 11'd1027, 1'b1});
    check("t4_last_byte", 32'(byte_log[(n_valid - 1) % 4096]), 32'h02);
    check("t4_sop", 32'(n_sop - b_sop), 32'd1);

    // Flags cleared: next packet is clean
    send_std(1'b0);
    check("t4b_len_err", {20'd0, eop_len, eop_err}, {20'd0, 11'd3, 1'b0});

    // Reset during byte 2 with DIR held high
    drv(1'b1, 1'b0, 8'hFF, 1'b0);
    drv(1'b1, 1'b0, 8'h10, 1'b0);
    drv(1'b1, 1'b1, 8'hC3, 1'b0);
    @(negedge clk_ext);
    rst = 1'b0;
    ULPI_DATA_IN = 8'h01;
    #1;
    check("t5_rst_outs", {30'd0, RX_ACTIVE, RX_VALID}, 32'd0);
    snap();
    drv(1'b1, 1'b1, 8'h02, 1'b0);
    drv(1'b1, 1'b1, 8'h03, 1'b0);
    @(negedge clk_ext);
    rst = 1'b1;
    ULPI_DATA_IN = 8'h04;
    drv(1'b1, 1'b1, 8'h05, 1'b0);
    drv(1'b1, 1'b0, 8'h10, 1'b0);
    drv(1'b1, 1'b1, 8'h06, 1'b0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    drv(1'b1, 1'b1, 8'h07, 1'b0);
    check("t5_quiet_active", 32'(RX_ACTIVE), 32'd0);
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    idle(4);
    check("t5_no_valid", 32'(n_valid - b_valid), 32'd0);
    check("t5_no_upd", 32'(n_upd - b_upd), 32'd0);
    check("t5_no_eop", 32'(n_eop - b_eop), 32'd0);
    snap();
    send_std(1'b0);
    check("t5_next_valid", 32'(n_valid - b_valid), 32'd3);
    check("t5_next_len_err", {20'd0, eop_len, eop_err}, {20'd0, 11'd3, 1'b0});
    check("t5_next_sopdata", 32'(sop_data), 32'hC3);

    // RxError mid-packet, full status decode, bit 7 ignored
    snap();
    drv(1'b1, 1'b0, 8'hFF, 1'b0);
    drv(1'b1, 1'b0, 8'h10, 1'b0);
    drv(1'b1, 1'b1, 8'hAA, 1'b0);
    drv(1'b1, 1'b0, 8'h30, 1'b0);
    drv(1'b1, 1'b1, 8'hBB, 1'b0);
    drv(1'b1, 1'b0, 8'hCE, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    idle(4);
    check("t6_valid", 32'(n_valid - b_valid), 32'd2);
    check("t6_len_err", {20'd0, eop_len, eop_err}, {20'd0, 11'd2, 1'b1});
    check("t6_upd", 32'(n_upd - b_upd), 32'd3);
    check("t6_status", {25'd0, LINESTATE, VBUS_STATE, RX_EVENT, ID_GND},
                       {25'd0, 2'b10, 2'b11, 2'b00, 1'b1});

    // Back-to-back packets without DIR dropping
    snap();
    drv(1'b1, 1'b0, 8'hFF, 1'b0);
    drv(1'b1, 1'b0, 8'h10, 1'b0);
    drv(1'b1, 1'b1, 8'h11, 1'b0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    drv(1'b1, 1'b0, 8'h10, 1'b0);
    drv(1'b1, 1'b1, 8'h22, 1'b0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    idle(4);
    check("t7_eops", 32'(n_eop - b_eop), 32'd2);
    check("t7_sops", 32'(n_sop - b_sop), 32'd2);
    check("t7_len", 32'(eop_len), 32'd1);
    check("no_eop_sop_clash", 32'(n_clash), 32'd0);

`ifdef ULPI_RX_TIMESTAMP_EN
    // Two packets whose first bytes are 100 cycles apart
    snap();
    drv(1'b1, 1'b0, 8'hFF, 1'b0);
    drv(1'b1, 1'b0, 8'h10, 1'b0);
    drv(1'b1, 1'b1, 8'h5A, 1'b0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    idle(95);
    drv(1'b1, 1'b0, 8'hFF, 1'b0);
    drv(1'b1, 1'b0, 8'h10, 1'b0);
    drv(1'b1, 1'b1, 8'hA5, 1'b0);
    drv(1'b1, 1'b0, 8'h00, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    idle(4);
    check("ts_sops", 32'(n_sop - b_sop), 32'd2);
    check("ts_diff", 32'(16'(ts_log[(b_sop + 1) % 16] - ts_log[b_sop % 16])), 32'd100);
    check("ts_held", 32'(RX_TSTAMP), 32'(ts_log[(b_sop + 1) % 16]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
